// File: rtl/dot_pipeline_pkg.sv
// Shared width helpers and stage tag type for the dot_pipeline engine.
package dot_pipeline_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  function automatic int prod_width(input int width);
    return 32'sd2 * width;
  endfunction

  // Each pairwise-add level widens by one bit, so the tree output needs log2(lanes) extra bits
  function automatic int tree_width(input int width, input int lanes);
    return prod_width(width) + clog2(lanes);
  endfunction

  function automatic int out_width(input int width, input int lanes, input int guard);
    return tree_width(width, lanes) + guard;
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } stage_tag_t;

endpackage

// File: rtl/dot_adder_tree.sv
// Registered pairwise adder tree: log2(LANES) levels, one per stage, with the
// valid/last tag travelling alongside the data and a shared advance enable.
module dot_adder_tree
  import dot_pipeline_pkg::*;
#(
  parameter int  LANES = 4,
  parameter int  IN_W  = 64,
  localparam int K     = clog2(LANES),
  localparam int SUM_W = IN_W + K
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [LANES*IN_W-1:0] i_data,
  input  stage_tag_t            i_tag,
  output logic [SUM_W-1:0]      o_sum,
  output stage_tag_t            o_tag,
  output logic                  o_busy
);

  logic [K:0] w_lvl_valid;

  assign w_lvl_valid[0] = 1'b0;

  if (K == 0) begin : g_pass
    assign o_sum = i_data;
    assign o_tag = i_tag;
  end else begin : g_levels
    for (genvar l = 1; l <= K; l++) begin : g_lvl
      localparam int N = LANES >> l;
      localparam int W = IN_W + l;

      logic [2*N*(W-1)-1:0] w_src;
      stage_tag_t           w_src_tag;
      logic [N*W-1:0]       w_node;
      logic [N*W-1:0]       r_node;
      stage_tag_t           r_tag;

      if (l == 1) begin : g_first
        assign w_src     = i_data;
        assign w_src_tag = i_tag;
      end else begin : g_inner
        assign w_src     = g_lvl[l-1].r_node;
        assign w_src_tag = g_lvl[l-1].r_tag;
      end

      // pairwise sums of the previous level, zero-extended by one bit
      always_comb begin
        w_node = '0;
        for (int n = 0; n < N; n++) begin
          w_node[n*W +: W] = {1'b0, w_src[2*n*(W-1) +: W-1]}
                           + {1'b0, w_src[(2*n+1)*(W-1) +: W-1]};
        end
      end

      // level register: tag always advances, data only loads behind a real beat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_node <= '0;
          r_tag  <= '0;
        end else if (en) begin
          r_tag <= w_src_tag;
          if (w_src_tag.valid) begin
            r_node <= w_node;
          end
        end
      end

      assign w_lvl_valid[l] = r_tag.valid;
    end

    assign o_sum = g_lvl[K].r_node;
    assign o_tag = g_lvl[K].r_tag;
  end

  assign o_busy = |w_lvl_valid;

endmodule

// File: rtl/dot_pipeline.sv
// Streaming LANES-wide dot-product engine with multi-beat accumulation and a
// valid/ready result port. Define DOT_PIPELINE_OVF_EN to add the out_ovf flag.
module dot_pipeline
  import dot_pipeline_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  LANES     = 4,
  parameter int  ACC_GUARD = 8,
  localparam int OUT_W     = out_width(WIDTH, LANES, ACC_GUARD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   busy
`ifdef DOT_PIPELINE_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int PROD_W = prod_width(WIDTH);
  localparam int SUM_W  = tree_width(WIDTH, LANES);

  logic                    w_en;
  logic [LANES*PROD_W-1:0] w_prod;
  logic [LANES*PROD_W-1:0] r_prod;
  stage_tag_t              r_m_tag;
  logic [SUM_W-1:0]        w_sum;
  stage_tag_t              w_t_tag;
  logic                    w_tree_busy;
  logic [OUT_W-1:0]        w_sum_ext;
  logic [OUT_W-1:0]        w_acc_next;
  logic [OUT_W-1:0]        r_acc;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_valid;
  logic                    r_pending;

  // A stalled result freezes the whole pipe, accumulator included
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // lane multipliers, unsigned full-width products
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i*PROD_W +: PROD_W] = PROD_W'(in_a[i*WIDTH +: WIDTH])
                                 * PROD_W'(in_b[i*WIDTH +: WIDTH]);
    end
  end

  // product stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_m_tag <= '0;
    end else if (w_en) begin
      r_m_tag.valid <= in_valid;
      r_m_tag.last  <= in_valid && in_last;
      if (in_valid) begin
        r_prod <= w_prod;
      end
    end
  end

  if (LANES > 1) begin : g_tree
    dot_adder_tree #(
      .LANES (LANES),
      .IN_W  (PROD_W)
    ) u_tree (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (w_en),
      .i_data (r_prod),
      .i_tag  (r_m_tag),
      .o_sum  (w_sum),
      .o_tag  (w_t_tag),
      .o_busy (w_tree_busy)
    );
  end else begin : g_no_tree
    assign w_sum       = r_prod;
    assign w_t_tag     = r_m_tag;
    assign w_tree_busy = 1'b0;
  end

  assign w_sum_ext = OUT_W'(w_sum);

`ifdef DOT_PIPELINE_OVF_EN
  logic [OUT_W:0] w_acc_wide;
  logic           r_ovf_sticky;
  logic           r_out_ovf;

  assign w_acc_wide = {1'b0, r_acc} + {1'b0, w_sum_ext};
  assign w_acc_next = w_acc_wide[OUT_W-1:0];

  // per-vector sticky carry-out, published with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else if (w_en && w_t_tag.valid) begin
      if (w_t_tag.last) begin
        r_out_ovf    <= r_ovf_sticky || w_acc_wide[OUT_W];
        r_ovf_sticky <= 1'b0;
      end else begin
        r_ovf_sticky <= r_ovf_sticky || w_acc_wide[OUT_W];
      end
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign w_acc_next = r_acc + w_sum_ext;
`endif

  // accumulate / output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_pending   <= 1'b0;
    end else if (w_en) begin
      if (w_t_tag.valid && w_t_tag.last) begin
        r_out_data  <= w_acc_next;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_pending   <= 1'b0;
      end else if (w_t_tag.valid) begin
        r_acc       <= w_acc_next;
        r_out_valid <= 1'b0;
        r_pending   <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_m_tag.valid || w_tree_busy || r_out_valid || r_pending;

endmodule

// File: tb/tb_dot_pipeline.sv
// Randomised and directed bench for dot_pipeline (LANES=4 and LANES=1 builds)
// checked against a plain-arithmetic dot-product model with result queues.
module tb_dot_pipeline;

  localparam int OW4 = 26;
  localparam int OW1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           iv4, ir4, il4, ov4, or4, busy4;
  logic [31:0]    a4, b4;
  logic [OW4-1:0] od4;
  logic           iv1, ir1, il1, ov1, or1, busy1;
  logic [7:0]     a1, b1;
  logic [OW1-1:0] od1;
`ifdef DOT_PIPELINE_OVF_EN
  logic           ovf4, ovf1;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_out4  = 0;
  int n_out1  = 0;
  int first_out4 = -1;
  int last_out4  = -1;
  int n0;
  longint unsigned acc4 = 64'd0;
  longint unsigned acc1 = 64'd0;
  longint unsigned exp4[$];
  longint unsigned exp1[$];
  bit xovf4[$];
  bit xovf1[$];

  dot_pipeline #(.WIDTH(8), .LANES(4), .ACC_GUARD(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_last(il4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4)
`ifdef DOT_PIPELINE_OVF_EN
    , .out_ovf(ovf4)
`endif
  );

  dot_pipeline #(.WIDTH(8), .LANES(1), .ACC_GUARD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1)
`ifdef DOT_PIPELINE_OVF_EN
    , .out_ovf(ovf1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model: whole-vector dot products, results queued in acceptance order
  task automatic monitor();
    longint unsigned s;
    bit x;
    if (iv4 && ir4) begin
      s = 64'd0;
      for (int i = 0; i < 4; i++) s += longint'(a4[i*8 +: 8]) * longint'(b4[i*8 +: 8]);
      acc4 += s;
      if (il4) begin
        exp4.push_back(acc4 % (64'd1 << OW4));
        xovf4.push_back(acc4 >= (64'd1 << OW4));
        acc4 = 64'd0;
      end
    end
    if (iv1 && ir1) begin
      acc1 += longint'(a1) * longint'(b1);
      if (il1) begin
        exp1.push_back(acc1 % (64'd1 << OW1));
        xovf1.push_back(acc1 >= (64'd1 << OW1));
        acc1 = 64'd0;
      end
    end
    if (ov4 && or4) begin
      n_out4++;
      if (first_out4 < 0) first_out4 = cyc;
      last_out4 = cyc;
      if (exp4.size() == 0) check_val("dut4_spurious_result", 64'd1, 64'd0);
      else begin
        check_val("dut4_data", 64'(od4), exp4.pop_front());
        x = xovf4.pop_front();
`ifdef DOT_PIPELINE_OVF_EN
        check_val("dut4_ovf", 64'(ovf4), 64'(x));
`endif
      end
    end
    if (ov1 && or1) begin
      n_out1++;
      if (exp1.size() == 0) check_val("dut1_spurious_result", 64'd1, 64'd0);
      else begin
        check_val("dut1_data", 64'(od1), exp1.pop_front());
        x = xovf1.pop_front();
`ifdef DOT_PIPELINE_OVF_EN
        check_val("dut1_ovf", 64'(ovf1), 64'(x));
`endif
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set4(input logic v, input logic [31:0] a, input logic [31:0] b, input logic l);
    iv4 = v; a4 = a; b4 = b; il4 = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    iv1 = v; a1 = a; b1 = b; il1 = l;
  endtask

  initial begin
    rst_n = 1'b0;
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    set1(1'b0, 8'd0, 8'd0, 1'b0);
    or4 = 1'b1;
    or1 = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check_val("rst_out_valid4", 64'(ov4), 64'd0);
    check_val("rst_out_data4", 64'(od4), 64'd0);
    check_val("rst_busy4", 64'(busy4), 64'd0);
    check_val("rst_in_ready4", 64'(ir4), 64'd1);
    check_val("rst_out_valid1", 64'(ov1), 64'd0);
    check_val("rst_busy1", 64'(busy1), 64'd0);

    // single-beat vector, latency 4, one-cycle valid
    set4(1'b1, 32'h04030201, 32'h08070605, 1'b1);
    tick();
    set4(1'b0, $urandom, $urandom, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      check_val("lat_not_yet", 64'(ov4), 64'd0);
      tick();
    end
    check_val("lat_valid", 64'(ov4), 64'd1);
    check_val("single_70", 64'(od4), 64'd70);
    tick();
    check_val("valid_one_cycle", 64'(ov4), 64'd0);

    // two-beat vector -> one result of 74
    n0 = n_out4;
    set4(1'b1, 32'h04030201, 32'h08070605, 1'b0);
    tick();
    check_val("busy_partial", 64'(busy4), 64'd1);
    set4(1'b1, 32'h01010101, 32'h01010101, 1'b1);
    tick();
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check_val("two_beat_count", 64'(n_out4 - n0), 64'd1);

    // backpressure: three vectors, out_ready low on cycles 4..8
    n0 = n_out4;
    for (int t = 0; t < 16; t++) begin
      case (t)
        0:       set4(1'b1, 32'h04030201, 32'h08070605, 1'b1);
        1:       set4(1'b1, 32'h01010101, 32'h01010101, 1'b1);
        2:       set4(1'b1, 32'h04030201, 32'h00000000, 1'b1);
        default: set4(1'b0, 32'd0, 32'd0, 1'b0);
      endcase
      or4 = !(t >= 4 && t <= 8);
      #1;
      if (t <= 2) check_val("bp_accept", 64'(ir4), 64'd1);
      if (t >= 4 && t <= 8) begin
        check_val("bp_in_ready_low", 64'(ir4), 64'd0);
        check_val("bp_hold_valid", 64'(ov4), 64'd1);
        check_val("bp_hold_data", 64'(od4), 64'd70);
      end
      tick();
    end
    check_val("bp_result_count", 64'(n_out4 - n0), 64'd3);

    // wrap at OUT_W=16: 2*255*255 mod 65536, then a clean 2*3
    set1(1'b1, 8'd255, 8'd255, 1'b0);
    tick();
    set1(1'b1, 8'd255, 8'd255, 1'b1);
    tick();
    set1(1'b0, 8'd0, 8'd0, 1'b0);
    check_val("wrap_not_yet", 64'(ov1), 64'd0);
    tick();
    check_val("wrap_valid", 64'(ov1), 64'd1);
    check_val("wrap_data", 64'(od1), 64'd64514);
`ifdef DOT_PIPELINE_OVF_EN
    check_val("wrap_ovf_set", 64'(ovf1), 64'd1);
`endif
    tick();
    set1(1'b1, 8'd2, 8'd3, 1'b1);
    tick();
    set1(1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    check_val("small_data", 64'(od1), 64'd6);
`ifdef DOT_PIPELINE_OVF_EN
    check_val("small_ovf_clear", 64'(ovf1), 64'd0);
`endif
    tick();

    // reset in the middle of a vector
    set4(1'b1, 32'h05050505, 32'h05050505, 1'b0);
    tick();
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 64'(busy4), 64'd0);
    acc4 = 64'd0;
    exp4.delete();
    xovf4.delete();
    tick();
    rst_n = 1'b1;
    set4(1'b1, 32'h00000001, 32'h00000009, 1'b1);
    tick();
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    tick();
    check_val("midrst_valid", 64'(ov4), 64'd1);
    check_val("midrst_data", 64'(od4), 64'd9);
    tick();
    check_val("midrst_busy_done", 64'(busy4), 64'd0);

    // throughput: 16 vectors back to back
    n0 = n_out4;
    first_out4 = -1;
    for (int i = 0; i < 16; i++) begin
      set4(1'b1, $urandom, $urandom, 1'b1);
      #1;
      check_val("tput_in_ready", 64'(ir4), 64'd1);
      tick();
    end
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check_val("tput_count", 64'(n_out4 - n0), 64'd16);
    check_val("tput_span", 64'(last_out4 - first_out4), 64'd15);

    // random traffic on both builds
    for (int i = 0; i < 600; i++) begin
      set4($urandom_range(3) != 32'd0, $urandom, $urandom, $urandom_range(2) == 32'd0);
      set1($urandom_range(3) != 32'd0, 8'($urandom), 8'($urandom), $urandom_range(1) == 32'd0);
      or4 = $urandom_range(3) != 32'd0;
      or1 = $urandom_range(3) != 32'd0;
      tick();
    end
    set4(1'b0, 32'd0, 32'd0, 1'b0);
    set1(1'b0, 8'd0, 8'd0, 1'b0);
    or4 = 1'b1;
    or1 = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check_val("drain_dut4", 64'(exp4.size()), 64'd0);
    check_val("drain_dut1", 64'(exp1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
